// File: rtl/cacheline_burst_adaptor.sv
// Purpose : splits/assembles one LINE_W cacheline into BEATS memory beats of BURST_W (LLC <-> DRAM burst port).
// Latency : resp_o pulses BEATS+1 cycles after the accept cycle when resp_i is held high; gaps in resp_i add cycles 1:1.
// Backpressure: memory side throttles with resp_i (one beat per resp_i cycle); LLC side sees a single resp_o pulse per line.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   line_i / line_o           write line from LLC (captured on accept) / assembled read line (held until next read)
//   address_i / address_o     LLC request address / line-aligned memory address
//   read_i, write_i           LLC requests (level); read wins when both are high
//   resp_o, err_o             one-cycle completion pulse / abort pulse (coincides with resp_o)
//   burst_i / burst_o         read beat from memory / write beat to memory
//   read_o, write_o           memory request, held for the whole transfer
//   resp_i                    memory beat handshake
//
// Optional feature macro: CLA_TIMEOUT_EN -- aborts a transfer after TIMEOUT_CYC consecutive idle beat cycles.
module cacheline_burst_adaptor #(
   parameter int LINE_W      = 256,
   parameter int BURST_W     = 64,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LINE_W-1:0]   line_i,
   output logic [LINE_W-1:0]   line_o,
   input  logic [ADDR_W-1:0]   address_i,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   output logic                err_o,
   input  logic [BURST_W-1:0]  burst_i,
   output logic [BURST_W-1:0]  burst_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int OFS_W = $clog2(LINE_W / 8);
   // One extra bit so the counter can reach BEATS without wrapping.
   localparam int CNT_W = $clog2(BEATS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_beat;
   logic [LINE_W-1:0]   r_wbuf;
   logic [LINE_W-1:0]   r_line;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   w_wshift;
   logic                w_busy;
   logic                w_beat;
   logic                w_last;
   logic                w_accept;
   logic                w_accept_wr;
   logic                w_timeout;
   logic                w_unused_ofs;

   assign w_busy      = (r_state == S_RD) || (r_state == S_WR);
   assign w_beat      = w_busy && resp_i;
   assign w_last      = w_beat && (r_beat == CNT_W'(BEATS - 1));
   assign w_accept    = (r_state == S_IDLE) && (read_i || write_i);
   assign w_accept_wr = (r_state == S_IDLE) && !read_i && write_i;

   // Byte-offset bits of the request address are dropped by alignment.
   assign w_unused_ofs = ^address_i[OFS_W-1:0];

`ifdef CLA_TIMEOUT_EN
   localparam int ST_W = $clog2(TIMEOUT_CYC + 1);

   logic [ST_W-1:0] r_stall;
   logic            r_err;

   // Fires on the edge where the stall run reaches TIMEOUT_CYC cycles.
   assign w_timeout = w_busy && !resp_i && (r_stall == ST_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (w_busy && !resp_i)
            r_stall <= r_stall + 1'b1;
         else
            r_stall <= '0;
      end
   end

   assign err_o = r_err;
`else
   assign w_timeout = 1'b0;
   assign err_o     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (read_i)
               w_next = S_RD;
            else if (write_i)
               w_next = S_WR;
         end
         S_RD, S_WR: begin
            if (w_last || w_timeout)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Current write beat selected from the registered counter.
   assign w_wshift = r_wbuf >> (32'(r_beat) * BURST_W);

   // Output logic
   always_comb begin
      read_o  = (r_state == S_RD);
      write_o = (r_state == S_WR);
      resp_o  = (r_state == S_DONE);
      burst_o = '0;
      if (r_state == S_WR)
         burst_o = w_wshift[BURST_W-1:0];
   end

   // Datapath: address/line capture, beat counter, read assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= '0;
         r_addr <= '0;
         r_wbuf <= '0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= {address_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            r_beat <= '0;
         end
         if (w_accept_wr)
            r_wbuf <= line_i;
         if (w_beat) begin
            r_beat <= r_beat + 1'b1;
            if (r_state == S_RD) begin
               for (int b = 0; b < BEATS; b++) begin
                  if (r_beat == CNT_W'(b))
                     r_line[b*BURST_W +: BURST_W] <= burst_i;
               end
            end
         end
      end
   end

   assign address_o = r_addr;
   assign line_o    = r_line;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: table of line transfers on the
// default 256/64 instance plus hand sequences for priority, reset, geometry and stall.
module tb_cacheline_burst_adaptor;

   logic clk;
   logic rst;

   // default 256/64 instance
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o, err_o, read_o, write_o, resp_i;
   logic [63:0]  burst_i, burst_o;

   // 512/128 instance
   logic [511:0] line_i_b, line_o_b;
   logic [31:0]  address_i_b, address_o_b;
   logic         read_i_b, write_i_b, resp_o_b, err_o_b, read_o_b, write_o_b, resp_i_b;
   logic [127:0] burst_i_b, burst_o_b;

   // 64/64 single-beat instance
   logic [63:0]  line_i_c, line_o_c;
   logic [31:0]  address_i_c, address_o_c;
   logic         read_i_c, write_i_c, resp_o_c, err_o_c, read_o_c, write_o_c, resp_i_c;
   logic [63:0]  burst_i_c, burst_o_c;

   cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
      .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .err_o(err_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

   cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(128), .ADDR_W(32), .TIMEOUT_CYC(64)) dut_b (
      .clk(clk), .rst(rst), .line_i(line_i_b), .line_o(line_o_b), .address_i(address_i_b),
      .read_i(read_i_b), .write_i(write_i_b), .resp_o(resp_o_b), .err_o(err_o_b),
      .burst_i(burst_i_b), .burst_o(burst_o_b), .address_o(address_o_b),
      .read_o(read_o_b), .write_o(write_o_b), .resp_i(resp_i_b));

   cacheline_burst_adaptor #(.LINE_W(64), .BURST_W(64), .ADDR_W(32), .TIMEOUT_CYC(64)) dut_c (
      .clk(clk), .rst(rst), .line_i(line_i_c), .line_o(line_o_c), .address_i(address_i_c),
      .read_i(read_i_c), .write_i(write_i_c), .resp_o(resp_o_c), .err_o(err_o_c),
      .burst_i(burst_i_c), .burst_o(burst_o_c), .address_o(address_o_c),
      .read_o(read_o_c), .write_o(write_o_c), .resp_i(resp_i_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0]  exp_beats[$];
   logic [255:0] exp_lines[$];

   typedef struct {
      bit           rd;
      logic [31:0]  addr;
      logic [255:0] data;
      int           gap;
      logic [31:0]  exp_addr;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory-side responder for the default instance. Entered at the negedge of the
   // first busy cycle; returns at the negedge of the IDLE cycle following resp_o.
   task automatic serve(input bit rd, input logic [255:0] data, input int gap,
                        output int cyc, output int hi);
      int  nb   = 0;
      int  gc   = 0;
      bit  done = 0;
      cyc = 0;
      hi  = 0;
      while (!done && cyc < 200) begin
         cyc++;
         if (resp_o) begin
            done   = 1;
            resp_i = 1'b0;
            if (rd) read_i = 1'b0; else write_i = 1'b0;
            chk("busy_drop", {read_o, write_o}, 0);
            chk("err_o_ok", err_o, 0);
            chk("beat_count", nb, 4);
            if (rd) begin
               if (exp_lines.size() == 0) chk("line_queue", 0, 1);
               else chk("line_o", line_o, exp_lines.pop_front());
            end
            @(negedge clk);
            chk("resp_pulse", resp_o, 0);
         end else begin
            if (read_o || write_o) hi++;
            if (nb < 4 && gc == 0) begin
               resp_i = 1'b1;
               if (rd) burst_i = data[nb*64 +: 64];
               else if (exp_beats.size() == 0) chk("beat_queue", 0, 1);
               else chk("burst_o", burst_o, exp_beats.pop_front());
               nb++;
               gc = gap;
            end else begin
               resp_i  = 1'b0;
               burst_i = {$urandom, $urandom};
               if (!rd && nb < 4 && exp_beats.size() > 0) chk("burst_hold", burst_o, exp_beats[0]);
               if (gc > 0) gc--;
            end
            @(negedge clk);
         end
      end
      if (!done) chk("resp_timeout", 0, 1);
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, hi;
      @(negedge clk);
      read_i    = v.rd;
      write_i   = !v.rd;
      address_i = v.addr;
      line_i    = v.data;
      if (v.rd) exp_lines.push_back(v.data);
      else for (int b = 0; b < 4; b++) exp_beats.push_back(v.data[b*64 +: 64]);
      @(negedge clk);
      // Request and its data change right after accept; transfer must not notice.
      read_i    = 1'b0;
      write_i   = 1'b0;
      address_i = $urandom;
      line_i    = {8{$urandom}};
      chk("address_o", address_o, v.exp_addr);
      serve(v.rd, v.data, v.gap, cyc, hi);
      chk("latency", cyc, 5 + 3 * v.gap);
      chk("req_cycles", hi, 4 + 3 * v.gap);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, hi, resp_seen;
      logic [255:0] l256, w256;
      logic [511:0] l512;
      logic [63:0]  v64;

      vecs[0] = '{1'b1, 32'h0000_1234,
                  {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A},
                  0, 32'h0000_1220};
      vecs[1] = '{1'b0, 32'h0000_0044,
                  {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                  1, 32'h0000_0040};
      vecs[2] = '{1'b1, 32'hFFFF_FFFF,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'hFFFF_0000_FFFF_0000},
                  2, 32'hFFFF_FFE0};
      vecs[3] = '{1'b0, 32'h8000_001F,
                  {64'hCAFE_F00D_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666},
                  0, 32'h8000_0000};

      rst = 1'b1;
      line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
      line_i_b = '0; address_i_b = '0; read_i_b = 0; write_i_b = 0; burst_i_b = '0; resp_i_b = 0;
      line_i_c = '0; address_i_c = '0; read_i_c = 0; write_i_c = 0; burst_i_c = '0; resp_i_c = 0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ctrl", {read_o, write_o, resp_o, err_o}, 0);
      chk("rst_addr", address_o, 0);
      chk("rst_line", line_o, 0);
      chk("rst_burst", burst_o, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Read and write together: read first, write taken in the IDLE after DONE.
      l256 = {8{$urandom}};
      w256 = {8{$urandom}};
      @(negedge clk);
      read_i = 1'b1; write_i = 1'b1; address_i = 32'h2000_0010; line_i = w256;
      exp_lines.push_back(l256);
      for (int b = 0; b < 4; b++) exp_beats.push_back(w256[b*64 +: 64]);
      @(negedge clk);
      chk("prio_rd", {read_o, write_o}, 2'b10);
      chk("prio_addr", address_o, 32'h2000_0000);
      serve(1'b1, l256, 0, cyc, hi);
      chk("prio_idle", write_o, 0);
      @(negedge clk);
      chk("prio_wr", {read_o, write_o}, 2'b01);
      serve(1'b0, w256, 0, cyc, hi);
      chk("prio_wr_cycles", hi, 4);

      // Reset after two read beats aborts without resp_o.
      @(negedge clk);
      read_i = 1'b1; address_i = 32'h0000_3000;
      @(negedge clk);
      read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h1111;
      @(negedge clk);
      burst_i = 64'h2222;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; resp_i = 1'b0;
      chk("midrst_ctrl", {read_o, write_o, resp_o, err_o}, 0);
      chk("midrst_addr", address_o, 0);
      chk("midrst_line", line_o, 0);
      @(negedge clk);
      chk("midrst_noresp", resp_o, 0);
      vecs[0].data = {8{$urandom}};
      run_vec(vecs[0]);

      // 512/128 geometry
      l512 = {16{$urandom}};
      @(negedge clk);
      read_i_b = 1'b1; address_i_b = 32'h1234_5678;
      @(negedge clk);
      read_i_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         resp_i_b = 1'b1; burst_i_b = l512[k*128 +: 128];
         @(negedge clk);
      end
      resp_i_b = 1'b0;
      chk("b_resp", resp_o_b, 1);
      chk("b_addr", address_o_b, 32'h1234_5640);
      chk("b_line", line_o_b, l512);
      @(negedge clk);
      chk("b_resp_pulse", resp_o_b, 0);

      // 64/64 single beat: resp_o two cycles after accept.
      v64 = {$urandom, $urandom};
      @(negedge clk);
      read_i_c = 1'b1; address_i_c = 32'h0000_0ABC;
      @(negedge clk);
      read_i_c = 1'b0;
      chk("c_rd", {read_o_c, resp_o_c}, 2'b10);
      resp_i_c = 1'b1; burst_i_c = v64;
      @(negedge clk);
      resp_i_c = 1'b0;
      chk("c_resp", resp_o_c, 1);
      chk("c_line", line_o_c, v64);
      chk("c_addr", address_o_c, 32'h0000_0AB8);
      v64 = {$urandom, $urandom};
      @(negedge clk);
      write_i_c = 1'b1; line_i_c = v64;
      @(negedge clk);
      write_i_c = 1'b0; line_i_c = '0;
      chk("c_burst", burst_o_c, v64);
      resp_i_c = 1'b1;
      @(negedge clk);
      resp_i_c = 1'b0;
      chk("c_wresp", {resp_o_c, write_o_c}, 2'b10);

      // No memory response after a read accept.
      @(negedge clk);
      read_i = 1'b1; address_i = 32'h0000_0100;
      @(negedge clk);
      read_i = 1'b0; resp_i = 1'b0;
      hi = 0; resp_seen = 0;
`ifdef CLA_TIMEOUT_EN
      for (int c = 0; c < 8; c++) begin
         if (read_o) hi++;
         if (resp_o) resp_seen++;
         @(negedge clk);
      end
      chk("to_read_cycles", hi, 8);
      chk("to_no_early_resp", resp_seen, 0);
      chk("to_abort", {resp_o, err_o, read_o}, 3'b110);
      @(negedge clk);
      chk("to_after", {resp_o, err_o}, 0);
`else
      for (int c = 0; c < 100; c++) begin
         if (read_o) hi++;
         if (resp_o || err_o) resp_seen++;
         @(negedge clk);
      end
      chk("stall_read_cycles", hi, 100);
      chk("stall_no_resp", resp_seen, 0);
      l256 = {8{$urandom}};
      exp_lines.push_back(l256);
      serve(1'b1, l256, 0, cyc, hi);
      chk("stall_finish", cyc, 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
